// File: rtl/prm_edge_mask_collector.sv
// Scan sequencer for the PRM obstacle-check array: broadcasts obstacle codes to the
// edge checkers, ORs their returned masks into a blocked-edge bitmap, then streams it out.
module prm_edge_mask_collector #(
    parameter  int NUM_EDGES = 1024,
    parameter  int WORD_W    = 32,
    localparam int NWORDS    = NUM_EDGES / WORD_W,
    localparam int IW        = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 obs_valid,
    output logic                 obs_ready,
    input  logic [14:0]          obs_code,
    input  logic                 obs_last,
    output logic [14:0]          chk_code,
    input  logic [NUM_EDGES-1:0] chk_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_data,
    output logic [IW-1:0]        out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DUMP} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    state_t                         state;
    logic [NWORDS-1:0][WORD_W-1:0]  bitmap;
    logic                           pend;

    // chk_code -> checker array -> chk_mask -> bitmap OR is the single-cycle closing path.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            bitmap    <= '0;
            chk_code  <= '0;
            pend      <= 1'b0;
            out_index <= '0;
            obs_ready <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pend)
                bitmap <= bitmap | chk_mask;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        bitmap    <= '0;
                        state     <= S_LOAD;
                        obs_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (obs_valid && obs_ready) begin
                        chk_code <= obs_code;
                        pend     <= 1'b1;
                        if (obs_last) begin
                            state     <= S_DRAIN;
                            obs_ready <= 1'b0;
                        end
                    end else begin
                        pend <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // The last code's mask is folded in by the pend OR above this cycle.
                    pend      <= 1'b0;
                    state     <= S_DUMP;
                    out_valid <= 1'b1;
                    out_index <= '0;
                end
                S_DUMP: begin
                    if (out_ready) begin
                        if (out_index == LAST_IDX) begin
                            state     <= S_IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            out_index <= '0;
                        end else begin
                            out_index <= out_index + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign out_data = out_valid ? bitmap[out_index] : '0;
    assign out_last = out_valid && (out_index == LAST_IDX);

endmodule

// File: tb/tb_prm_edge_mask_collector.sv
// Directed bench for prm_edge_mask_collector with a behavioural one-hot edge-checker array.
module tb_prm_edge_mask_collector;

    localparam int NUM_EDGES = 1024;
    localparam int WORD_W    = 32;
    localparam int NWORDS    = NUM_EDGES / WORD_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 obs_valid;
    logic                 obs_ready;
    logic [14:0]          obs_code;
    logic                 obs_last;
    logic [14:0]          chk_code;
    logic [NUM_EDGES-1:0] chk_mask;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_W-1:0]    out_data;
    logic [4:0]           out_index;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_w [NWORDS];

    prm_edge_mask_collector #(.NUM_EDGES(NUM_EDGES), .WORD_W(WORD_W)) dut (
        .CLK(clk), .RST(rst), .start(start),
        .obs_valid(obs_valid), .obs_ready(obs_ready), .obs_code(obs_code), .obs_last(obs_last),
        .chk_code(chk_code), .chk_mask(chk_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Checker model: edge e fires only on code {5'h18, e ^ 10'h1B8}; edge 970 <-> 15'h6272.
    always_comb begin
        chk_mask = '0;
        if (chk_code[14:10] == 5'h18)
            chk_mask[chk_code[9:0] ^ 10'h1B8] = 1'b1;
    end

    function automatic logic [14:0] code_of(input int e);
        logic [9:0] lo;
        lo = e[9:0] ^ 10'h1B8;
        return {5'h18, lo};
    endfunction

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < NWORDS; i++) exp_w[i] = '0;
    endtask

    task automatic start_scan();
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        expect_eq("start_busy", busy, 1);
        expect_eq("start_obs_ready", obs_ready, 1);
    endtask

    task automatic send(input logic [14:0] code, input bit last);
        obs_valid = 1'b1;
        obs_code  = code;
        obs_last  = last;
        expect_eq("load_obs_ready", obs_ready, 1);
        @(posedge clk) #1;
        obs_valid = 1'b0;
        obs_last  = 1'b0;
        expect_eq("chk_code", chk_code, code);
    endtask

    // Entered one cycle after obs_last was accepted (DRAIN cycle).
    task automatic run_dump(input bit random_ready, input bit abuse);
        int nexp;
        bit pstall;
        logic [31:0] pdata;
        logic [4:0]  pidx;
        nexp   = 0;
        pstall = 1'b0;
        pdata  = '0;
        pidx   = '0;
        expect_eq("drain_out_valid", out_valid, 0);
        expect_eq("drain_obs_ready", obs_ready, 0);
        for (int cyc = 0; cyc < 400 && nexp < NWORDS; cyc++) begin
            @(posedge clk) #1;
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (abuse) begin
                start     = (cyc == 3);
                obs_valid = 1'b1;
                obs_code  = code_of(200);
                expect_eq("dump_obs_ready", obs_ready, 0);
            end
            if (cyc == 0 || !random_ready)
                expect_eq("dump_out_valid", out_valid, 1);
            if (pstall) begin
                expect_eq("hold_data", out_data, pdata);
                expect_eq("hold_index", out_index, pidx);
            end
            pstall = out_valid && !out_ready;
            pdata  = out_data;
            pidx   = out_index;
            if (out_valid && out_ready) begin
                expect_eq("word_index", out_index, nexp);
                expect_eq($sformatf("word_data[%0d]", nexp), out_data, exp_w[nexp]);
                expect_eq("word_last", out_last, (nexp == NWORDS - 1));
                nexp++;
            end
        end
        @(posedge clk) #1;
        out_ready = 1'b0;
        start     = 1'b0;
        obs_valid = 1'b0;
        expect_eq("dump_words", nexp, NWORDS);
        expect_eq("done_pulse", done, 1);
        expect_eq("done_busy", busy, 0);
        expect_eq("done_out_valid", out_valid, 0);
        @(posedge clk) #1;
        expect_eq("done_cleared", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b2b_edges [8];
        b2b_edges = '{0, 31, 32, 500, 970, 1023, 5, 6};
        rst = 1'b1; start = 1'b0; obs_valid = 1'b0; obs_code = '0; obs_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("rst_obs_ready", obs_ready, 0);
        expect_eq("rst_out_valid", out_valid, 0);
        expect_eq("rst_out_last", out_last, 0);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_done", done, 0);
        expect_eq("rst_out_data", out_data, 0);
        expect_eq("rst_out_index", out_index, 0);
        expect_eq("rst_chk_code", chk_code, 0);
        rst = 1'b0;
        @(posedge clk) #1;

        // Single hit: edge 970 -> word 30 bit 10
        clear_exp();
        exp_w[30] = 32'h0000_0400;
        start_scan();
        send(15'h6272, 1'b1);
        run_dump(1'b0, 1'b0);

        // Back-to-back codes, no bubbles
        clear_exp();
        exp_w[0]  = 32'h8000_0061;
        exp_w[1]  = 32'h0000_0001;
        exp_w[15] = 32'h0010_0000;
        exp_w[30] = 32'h0000_0400;
        exp_w[31] = 32'h8000_0000;
        start_scan();
        for (int i = 0; i < 8; i++) send(code_of(b2b_edges[i]), i == 7);
        run_dump(1'b0, 1'b0);

        // Empty scan
        clear_exp();
        start_scan();
        send(15'h0000, 1'b1);
        run_dump(1'b0, 1'b0);

        // Output backpressure: edges 33, 64, 700
        clear_exp();
        exp_w[1]  = 32'h0000_0002;
        exp_w[2]  = 32'h0000_0001;
        exp_w[21] = 32'h1000_0000;
        start_scan();
        send(code_of(33), 1'b0);
        send(code_of(64), 1'b0);
        send(code_of(700), 1'b1);
        run_dump(1'b1, 1'b0);

        // Protocol abuse: obs_valid in IDLE, start in LOAD and DUMP
        obs_valid = 1'b1;
        obs_code  = code_of(100);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            expect_eq("idle_obs_ready", obs_ready, 0);
            expect_eq("idle_busy", busy, 0);
        end
        obs_valid = 1'b0;
        clear_exp();
        exp_w[9] = 32'h0000_3000;
        start_scan();
        start = 1'b1;
        send(code_of(300), 1'b0);
        start = 1'b0;
        send(code_of(301), 1'b1);
        run_dump(1'b0, 1'b1);

        // Reset mid-LOAD
        start_scan();
        send(code_of(40), 1'b0);
        send(code_of(41), 1'b0);
        obs_valid = 1'b1;
        obs_code  = code_of(42);
        rst = 1'b1;
        #1;
        expect_eq("abort_obs_ready", obs_ready, 0);
        expect_eq("abort_out_valid", out_valid, 0);
        expect_eq("abort_busy", busy, 0);
        expect_eq("abort_done", done, 0);
        expect_eq("abort_out_data", out_data, 0);
        expect_eq("abort_chk_code", chk_code, 0);
        @(posedge clk) #1;
        rst = 1'b0;
        obs_valid = 1'b0;
        @(posedge clk) #1;
        clear_exp();
        start_scan();
        send(15'h0000, 1'b1);
        run_dump(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
